// File: rtl/div_unit_pkg.sv
// Shared encodings for the divider: FSM state codes and the EX-stage opcodes
// that select DIV / DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left by one bit, then
// subtract the divisor from the partial remainder when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] rem_sh;
    logic           take;

    // The compare uses WIDTH+1 bits, but the difference always fits in WIDTH
    // bits, so the subtraction is done on the low bits only.
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        take   = (rem_sh >= {1'b0, div_i});
        rem_o  = take ? (rem_sh[WIDTH-1:0] - div_i) : rem_sh[WIDTH-1:0];
        quo_o  = {quo_i[WIDTH-2:0], take};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU producing {remainder, quotient}.
// Optional feature: define DIV_ZERO_FAST_EN to finish divide-by-zero in a single cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output div_state_e         dbg_state
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic               neg_q_q, neg_r_q;
    logic               busy_q, done_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               neg_q_in, neg_r_in;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    always_comb begin
        abs_a    = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        abs_b    = (signed_div && opb[WIDTH-1]) ? -opb : opb;
        neg_q_in = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        neg_r_in = signed_div & opa[WIDTH-1];
        rem_fix  = neg_r_q ? -rem_nxt : rem_nxt;
        quo_fix  = neg_q_q ? -quo_nxt : quo_nxt;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DIV_IDLE, DIV_DONE: begin
                    // annul beats a simultaneous start: the request is dropped
                    if (annul || !start) begin
                        state_q <= DIV_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q   <= '0;
                        quo_q   <= abs_a;
                        dvs_q   <= abs_b;
                        neg_q_q <= neg_q_in;
                        neg_r_q <= neg_r_in;
                        cnt_q   <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (opb == '0) begin
                            state_q  <= DIV_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= {neg_r_in ? -abs_a : abs_a,
                                         neg_q_in ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}}};
                        end else begin
                            state_q <= DIV_BUSY;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= DIV_BUSY;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                DIV_BUSY: begin
                    if (annul) begin
                        state_q <= DIV_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        // sign fix-up is folded into the final iteration's write
                        if (cnt_q == LAST_CNT) begin
                            state_q  <= DIV_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule
